// File: rtl/ex_operand_stage.sv
// ex_operand_stage: execute-stage operand select and ID/EX register.
// Ports: clk/rst, stall/flush, stage-2 IR2/A2/B2, Z4/Z5 forward sources,
// forward enables/selects, stage-3 IR3/A3/B3/SD3/valid3, perf counters.
module ex_operand_stage #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          valid2,
    input  logic [W-1:0]  IR2,
    input  logic [W-1:0]  A2,
    input  logic [W-1:0]  B2,
    input  logic [W-1:0]  Z4,
    input  logic [W-1:0]  Z5,
    input  logic          forward1_ex,
    input  logic          z4_z5_logical_1,
    input  logic          forward2_ex,
    input  logic          z4_z5_logical_2,
    input  logic          forward_sw_ex,
    input  logic          z4_z5_sw_ex,
    output logic [W-1:0]  IR3,
    output logic          valid3,
    output logic [W-1:0]  A3,
    output logic [W-1:0]  B3,
    output logic [W-1:0]  SD3,
    output logic [CW-1:0] fwd_cnt,
    output logic [CW-1:0] bubble_cnt
);

    localparam logic [4:0] OP_SW = 5'b01011;

    logic          is_sw;
    logic          fwd2_eff;
    logic          fwd_sw_eff;
    logic          any_fwd;
    logic          bubble;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  sd;

    // Stores route forwarded data only through sd; other ops only through opB.
    assign is_sw      = (IR2[31:27] == OP_SW);
    assign fwd2_eff   = forward2_ex & ~is_sw;
    assign fwd_sw_eff = forward_sw_ex & is_sw;
    assign any_fwd    = forward1_ex | fwd2_eff | fwd_sw_eff;

    assign op_a = forward1_ex ? (z4_z5_logical_1 ? Z5 : Z4) : A2;
    assign op_b = fwd2_eff    ? (z4_z5_logical_2 ? Z5 : Z4) : B2;
    assign sd   = fwd_sw_eff  ? (z4_z5_sw_ex     ? Z5 : Z4) : B2;

    // Flush beats stall; an empty slot only becomes a bubble when not stalled.
    assign bubble = flush | (~stall & ~valid2);

    always_ff @(posedge clk) begin
        if (rst) begin
            IR3        <= '0;
            valid3     <= 1'b0;
            A3         <= '0;
            B3         <= '0;
            SD3        <= '0;
            fwd_cnt    <= '0;
            bubble_cnt <= '0;
        end else if (bubble) begin
            IR3    <= '0;
            valid3 <= 1'b0;
            A3     <= '0;
            B3     <= '0;
            SD3    <= '0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end else if (!stall) begin
            IR3    <= IR2;
            valid3 <= 1'b1;
            A3     <= op_a;
            B3     <= op_b;
            SD3    <= sd;
            if (any_fwd && fwd_cnt != '1)
                fwd_cnt <= fwd_cnt + 1'b1;
        end
    end

endmodule
